// File: rtl/ps2_hex_entry.sv
// PS/2 keyboard receiver that turns scan-code-set-2 make codes into code/hex pulses.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_hex_entry #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       hex_valid,
  output logic [3:0] hex_nibble,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] data_sync_reg;

  // Synchronizers clear to 0 so a low pin right after reset is never seen as a falling edge.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) begin
            clk_sync_reg[gi]  <= 1'b0;
            data_sync_reg[gi] <= 1'b0;
          end else begin
            clk_sync_reg[gi]  <= ps2_clk;
            data_sync_reg[gi] <= ps2_data;
          end
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (rst) begin
            clk_sync_reg[gi]  <= 1'b0;
            data_sync_reg[gi] <= 1'b0;
          end else begin
            clk_sync_reg[gi]  <= clk_sync_reg[gi-1];
            data_sync_reg[gi] <= data_sync_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  logic clk_s;
  logic data_s;
  logic clk_prev_reg;
  logic fall;

  assign clk_s  = clk_sync_reg[SYNC_STAGES-1];
  assign data_s = data_sync_reg[SYNC_STAGES-1];
  assign fall   = clk_prev_reg & ~clk_s;

  logic [1:0]    state_reg, state_next;
  logic [3:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          parity_reg, parity_next;
  logic          break_pending_reg, break_pending_next;
  logic          ext_pending_reg, ext_pending_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic [7:0]    code_reg, code_next;
  logic [3:0]    hex_nibble_reg, hex_nibble_next;
  logic          code_valid_reg, code_valid_next;
  logic          hex_valid_reg, hex_valid_next;
  logic          frame_err_reg, frame_err_next;

  logic       hex_hit;
  logic [3:0] hex_val;
  logic       parity_ok;

  always_comb begin
    hex_hit = 1'b1;
    hex_val = 4'h0;
    case (shift_reg)
      8'h45: hex_val = 4'h0;
      8'h16: hex_val = 4'h1;
      8'h1E: hex_val = 4'h2;
      8'h26: hex_val = 4'h3;
      8'h25: hex_val = 4'h4;
      8'h2E: hex_val = 4'h5;
      8'h36: hex_val = 4'h6;
      8'h3D: hex_val = 4'h7;
      8'h3E: hex_val = 4'h8;
      8'h46: hex_val = 4'h9;
      8'h1C: hex_val = 4'hA;
      8'h32: hex_val = 4'hB;
      8'h21: hex_val = 4'hC;
      8'h23: hex_val = 4'hD;
      8'h24: hex_val = 4'hE;
      8'h2B: hex_val = 4'hF;
      default: hex_hit = 1'b0;
    endcase
  end

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{shift_reg, parity_reg};
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_next         = state_reg;
    bit_cnt_next       = bit_cnt_reg;
    shift_next         = shift_reg;
    parity_next        = parity_reg;
    break_pending_next = break_pending_reg;
    ext_pending_next   = ext_pending_reg;
    to_cnt_next        = to_cnt_reg;
    code_next          = code_reg;
    hex_nibble_next    = hex_nibble_reg;
    code_valid_next    = 1'b0;
    hex_valid_next     = 1'b0;
    frame_err_next     = 1'b0;

    if (fall) begin
      to_cnt_next = '0;
      case (state_reg)
        IDLE: begin
          if (!data_s) begin
            state_next   = DATA;
            bit_cnt_next = 4'd1;
          end else begin
            frame_err_next = 1'b1;
          end
        end
        DATA: begin
          shift_next   = {data_s, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd8) state_next = PARITY;
        end
        PARITY: begin
          parity_next  = data_s;
          bit_cnt_next = bit_cnt_reg + 4'd1;
          state_next   = STOP;
        end
        default: begin
          state_next   = IDLE;
          bit_cnt_next = 4'd0;
          if (data_s && parity_ok) begin
            // Prefix bytes arm flags; a byte after a prefix is swallowed (release or extended key).
            if (shift_reg == 8'hF0) begin
              break_pending_next = 1'b1;
            end else if (shift_reg == 8'hE0) begin
              ext_pending_next = 1'b1;
            end else if (break_pending_reg) begin
              break_pending_next = 1'b0;
              ext_pending_next   = 1'b0;
            end else if (ext_pending_reg) begin
              ext_pending_next = 1'b0;
            end else begin
              code_next       = shift_reg;
              code_valid_next = 1'b1;
              if (hex_hit) begin
                hex_nibble_next = hex_val;
                hex_valid_next  = 1'b1;
              end
            end
          end else begin
            frame_err_next = 1'b1;
          end
        end
      endcase
    end else if (bit_cnt_reg != 4'd0) begin
      if (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
        state_next     = IDLE;
        bit_cnt_next   = 4'd0;
        to_cnt_next    = '0;
        frame_err_next = 1'b1;
      end else begin
        to_cnt_next = to_cnt_reg + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_prev_reg      <= 1'b0;
      state_reg         <= IDLE;
      bit_cnt_reg       <= 4'd0;
      shift_reg         <= 8'd0;
      parity_reg        <= 1'b0;
      break_pending_reg <= 1'b0;
      ext_pending_reg   <= 1'b0;
      to_cnt_reg        <= '0;
      code_reg          <= 8'd0;
      hex_nibble_reg    <= 4'd0;
      code_valid_reg    <= 1'b0;
      hex_valid_reg     <= 1'b0;
      frame_err_reg     <= 1'b0;
    end else begin
      clk_prev_reg      <= clk_s;
      state_reg         <= state_next;
      bit_cnt_reg       <= bit_cnt_next;
      shift_reg         <= shift_next;
      parity_reg        <= parity_next;
      break_pending_reg <= break_pending_next;
      ext_pending_reg   <= ext_pending_next;
      to_cnt_reg        <= to_cnt_next;
      code_reg          <= code_next;
      hex_nibble_reg    <= hex_nibble_next;
      code_valid_reg    <= code_valid_next;
      hex_valid_reg     <= hex_valid_next;
      frame_err_reg     <= frame_err_next;
    end
  end

  assign code_valid = code_valid_reg;
  assign code       = code_reg;
  assign hex_valid  = hex_valid_reg;
  assign hex_nibble = hex_nibble_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = (bit_cnt_reg != 4'd0);

endmodule

// File: tb/tb_ps2_hex_entry.sv
// Directed bench for ps2_hex_entry: drives PS/2 frames and counts output pulses.
module tb_ps2_hex_entry;

  localparam int TO   = 300;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       code_valid;
  logic [7:0] code;
  logic       hex_valid;
  logic [3:0] hex_nibble;
  logic       frame_err;
  logic       busy;

  ps2_hex_entry #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code_valid (code_valid),
    .code       (code),
    .hex_valid  (hex_valid),
    .hex_nibble (hex_nibble),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_code = 0;
  int n_hex = 0;
  int n_err = 0;
  int c0, h0, e0;
  logic [7:0] exp_code;
  logic [3:0] exp_nib;

  // One count per cycle high, so a stretched pulse shows up as an extra pulse.
  always @(negedge clk) begin
    if (code_valid) n_code++;
    if (hex_valid)  n_hex++;
    if (frame_err)  n_err++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, act);
    end
  endtask

  task automatic snap();
    c0 = n_code;
    h0 = n_hex;
    e0 = n_err;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic ps2_edge(input logic b);
    ps2_data = b;
    wait_clks(HALF);
    ps2_clk = 1'b0;
    wait_clks(HALF);
    ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic flip_par,
                                             input logic bad_stop);
    return {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) ps2_edge(bits[i]);
    ps2_data = 1'b1;
    wait_clks(8);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(make_frame(b, 1'b0, 1'b0), 11);
  endtask

  initial begin
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rst code_valid", code_valid, 0);
    check_eq("rst code", code, 0);
    check_eq("rst hex_valid", hex_valid, 0);
    check_eq("rst hex_nibble", hex_nibble, 0);
    check_eq("rst frame_err", frame_err, 0);
    check_eq("rst busy", busy, 0);
    rst = 1'b0;
    wait_clks(10);

    // Abort in PARITY state via reset, then a good 0x16
    snap();
    send_bits(make_frame(8'h16, 1'b0, 1'b0), 9);
    check_eq("parity busy", busy, 1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_eq("midrst busy", busy, 0);
    wait_clks(5);
    @(negedge clk);
    check_eq("midrst no err", n_err - e0, 0);
    check_eq("midrst no code", n_code - c0, 0);
    send_byte(8'h16);
    check_eq("16 code_valid", n_code - c0, 1);
    check_eq("16 code", code, 8'h16);
    check_eq("16 hex_valid", n_hex - h0, 1);
    check_eq("16 nibble", hex_nibble, 4'h1);
    check_eq("16 no err", n_err - e0, 0);

    // Make then break of 0x1C
    snap();
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check_eq("1C code_valid", n_code - c0, 1);
    check_eq("1C hex_valid", n_hex - h0, 1);
    check_eq("1C code", code, 8'h1C);
    check_eq("1C nibble", hex_nibble, 4'hA);

    // Non-hex make code
    snap();
    send_byte(8'h29);
    check_eq("29 code_valid", n_code - c0, 1);
    check_eq("29 code", code, 8'h29);
    check_eq("29 hex_valid", n_hex - h0, 0);
    check_eq("29 nibble held", hex_nibble, 4'hA);

    // Extended make and break are swallowed
    snap();
    send_byte(8'hE0);
    send_byte(8'h75);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check_eq("ext code_valid", n_code - c0, 0);
    check_eq("ext hex_valid", n_hex - h0, 0);
    send_byte(8'h45);
    check_eq("45 code_valid", n_code - c0, 1);
    check_eq("45 nibble", hex_nibble, 4'h0);
    check_eq("45 hex_valid", n_hex - h0, 1);

    // Typematic repeat
    snap();
    send_byte(8'h45);
    send_byte(8'h45);
    check_eq("repeat code_valid", n_code - c0, 2);

    // Flipped parity on 0x26
    snap();
    send_bits(make_frame(8'h26, 1'b1, 1'b0), 11);
`ifdef PS2_PARITY_CHECK_EN
    check_eq("badpar err", n_err - e0, 1);
    check_eq("badpar code_valid", n_code - c0, 0);
    exp_code = 8'h45;
    exp_nib  = 4'h0;
`else
    check_eq("badpar err", n_err - e0, 0);
    check_eq("badpar code_valid", n_code - c0, 1);
    check_eq("badpar code", code, 8'h26);
    exp_code = 8'h26;
    exp_nib  = 4'h3;
`endif

    // Bad stop bit on 0x2E
    snap();
    send_bits(make_frame(8'h2E, 1'b0, 1'b1), 11);
    check_eq("badstop err", n_err - e0, 1);
    check_eq("badstop code_valid", n_code - c0, 0);
    check_eq("badstop code held", code, exp_code);
    check_eq("badstop nibble held", hex_nibble, exp_nib);

    // Bad start bit
    snap();
    ps2_edge(1'b1);
    wait_clks(8);
    @(negedge clk);
    check_eq("badstart err", n_err - e0, 1);
    check_eq("badstart busy", busy, 0);

    // Timeout after 5 edges, then recovery
    snap();
    send_bits(make_frame(8'h3E, 1'b0, 1'b0), 5);
    check_eq("to busy before", busy, 1);
    check_eq("to no early err", n_err - e0, 0);
    wait_clks(TO + 20);
    @(negedge clk);
    check_eq("to err", n_err - e0, 1);
    check_eq("to busy after", busy, 0);
    send_byte(8'h3E);
    check_eq("3E code", code, 8'h3E);
    check_eq("3E nibble", hex_nibble, 4'h8);
    check_eq("3E code_valid", n_code - c0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_hex_entry.md
Name: ps2_hex_entry

Overview:
- Operand-entry front end for the 4-bit ALU/seven-segment datapath. The display side drives data out to the board; this block brings data in from the board.
- Receives PS/2 keyboard frames (scan code set 2), validates them and filters break/extended codes.
- Emits make codes, plus a 4-bit hex nibble for keys 0-9/A-F, as single-cycle valid pulses.
- Downstream operand/op registers (A, B, op) load from these pulses.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the ps2_clk and ps2_data synchronizers (minimum 2).
- TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge mid-frame before the frame is aborted.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock from the pin; asynchronous.
- ps2_data  input  1  raw PS/2 data from the pin; asynchronous.
- code_valid  output  1  one-cycle pulse: a make code has been accepted.
- code  output  8  last accepted make code; held until the next accept.
- hex_valid  output  1  one-cycle pulse, coincident with code_valid, when the code maps to a hex digit.
- hex_nibble  output  4  mapped digit value; held until the next hex_valid.
- frame_err  output  1  one-cycle pulse on a bad start, parity or stop bit, or on timeout.
- busy  output  1  high while a frame is in progress (bit_cnt != 0).

Behaviour:
- Clock and reset:
  - Single clock clk; reset is synchronous, active-high on rst.
  - In the cycle after rst is sampled high, all outputs are 0 and all state is cleared: FSM in IDLE, bit_cnt=0, shift register=0, break_pending=0, ext_pending=0, timeout counter=0.
  - rst asserted mid-frame discards the partial frame with no frame_err.
- Synchronization and edge detect:
  - ps2_clk and ps2_data each pass through SYNC_STAGES flip-flops.
  - A falling edge is synced ps2_clk at 0 with its previous registered value at 1.
  - All sampling happens only on a detected falling edge.
- Frame: 11 bits, LSB first: start(0), d0..d7, odd parity, stop(1).
- FSM states:
  - IDLE: on an edge, if data=0 go to DATA with bit_cnt=1. If data=1, stay in IDLE and pulse frame_err (bad start).
  - DATA: shift data into bit 7 of the shift register, shifting right. After 8 data edges go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: on an edge, check stop=1 and odd parity over the 8 data bits plus the parity bit.
    - Pass: evaluate the byte in the same cycle (see below).
    - Fail: pulse frame_err.
    - Either way, return to IDLE.
- Byte evaluation on a good frame:
  - 0xF0: set break_pending; no output.
  - 0xE0: set ext_pending; no output.
  - Any other byte with break_pending=1: clear break_pending and ext_pending; no output (key release).
  - Any other byte with ext_pending=1 and no break pending: clear ext_pending; no output (extended keys ignored).
  - Otherwise: update code and pulse code_valid. If the byte is in the hex map, also update hex_nibble and pulse hex_valid.
- Hex map (set 2):
  - Digits: 45→0, 16→1, 1E→2, 26→3, 25→4, 2E→5, 36→6, 3D→7, 3E→8, 46→9.
  - Letters: 1C→A, 32→B, 21→C, 23→D, 24→E, 2B→F.
  - All other bytes are non-hex.
- Latency: pulses are registered and appear exactly 1 clk after the clk cycle in which the stop-bit edge was detected.
- Pulse width: all pulses are exactly one cycle wide.
- Typematic repeat: repeated make codes without an intervening release each produce a fresh pulse.
- Timeout:
  - The counter runs only while bit_cnt != 0 and clears on every detected falling edge.
  - When it reaches TIMEOUT_CYCLES-1: go to IDLE, bit_cnt=0, pulse frame_err.
  - Pending flags are preserved through a timeout.
- Error recovery: frame_err never alters break_pending or ext_pending.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: a parity mismatch pulses frame_err and the byte is discarded.
- Undefined:
  - The parity bit is sampled but ignored.
  - Only bad start, bad stop and timeout raise frame_err.
  - A frame with bad parity is accepted as good.

Test Plan:
- Reset during the PARITY state, then send a valid frame for 0x16 → no frame_err, busy=0 after reset; then code=0x16 with code_valid, and hex_nibble=1 with hex_valid.
- Make 0x1C, then break F0 1C → one code_valid with code=0x1C and hex_nibble=0xA; the F0 and the second 1C produce no pulses.
- Frame 0x29 (space) → code_valid=1 with code=0x29 and hex_valid=0; hex_nibble keeps its previous value.
- E0 75, then E0 F0 75 → no pulses; then 0x45 → hex_nibble=0 with hex_valid.
- Frame 0x26 with flipped parity → frame_err pulse and no code_valid when PS2_PARITY_CHECK_EN is defined; code_valid with code=0x26 when undefined. Bad stop bit → frame_err in both builds.
- Stop ps2_clk after 5 edges for TIMEOUT_CYCLES → frame_err pulse and busy=0; then a valid 0x3E frame → hex_nibble=8.
